// File: rtl/mem_pkg.sv
// Package for the block copy/fill engine.
// Holds the FSM state encoding, the op codes and the default widths shared by
// mem_copy_engine and mem_ptr_counter.
package mem_pkg;

   localparam int MEM_DATA_W = 16;
   localparam int MEM_ADDR_W = 16;
   localparam int MEM_LEN_W  = 16;

   localparam logic OP_COPY = 1'b0;
   localparam logic OP_FILL = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } engStateT;

endpackage

// File: rtl/mem_ptr_counter.sv
// Loadable address pointer with increment. Wraps modulo 2**W.
// Ports:
//   clk, reset   clock, asynchronous active-high reset (ptr -> 0)
//   load         load loadValue (has priority over inc)
//   inc          advance ptr by one
//   loadValue    base address to load
//   ptr          current pointer
module mem_ptr_counter
   import mem_pkg::*;
#(
   parameter int W = MEM_ADDR_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         inc,
   input  logic [W-1:0] loadValue,
   output logic [W-1:0] ptr
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)     ptr <= '0;
      else if (load) ptr <= loadValue;
      else if (inc)  ptr <= ptr + W'(1);
   end

endmodule

// File: rtl/mem_copy_engine.sv
// Block COPY / FILL bus initiator for the memory_block port.
// Issues one memory access per cycle while busy; COPY alternates READ/WRITE,
// FILL writes every cycle.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   start, op, src_addr, dst_addr,
//   len, fill_value                request and operands (captured in IDLE)
//   busy, done                     status toward control unit
//   mem_address, mem_data, mem_wEn memory port outputs
//   mem_outData                    combinational read data from memory
module mem_copy_engine
   import mem_pkg::*;
#(
   parameter int DATA_W = MEM_DATA_W,
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int LEN_W  = MEM_LEN_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              op,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  len,
   input  logic [DATA_W-1:0] fill_value,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_wEn,
   input  logic [DATA_W-1:0] mem_outData
);

   engStateT          state, stateNext;
   logic              opQ;
   logic [DATA_W-1:0] fillQ, holdQ, lastData;
   logic [ADDR_W-1:0] srcPtr, dstPtr, lastAddr;
   logic [LEN_W-1:0]  count;
   logic              accept;

   assign accept = (state == IDLE) && start;

   mem_ptr_counter #(.W(ADDR_W)) srcCtr (
      .clk(clk), .reset(reset), .load(accept), .inc(state == READ),
      .loadValue(src_addr), .ptr(srcPtr)
   );

   mem_ptr_counter #(.W(ADDR_W)) dstCtr (
      .clk(clk), .reset(reset), .load(accept), .inc(state == WRITE),
      .loadValue(dst_addr), .ptr(dstPtr)
   );

   always_comb begin
      stateNext = state;
      case (state)
         IDLE: begin
            if (start) begin
               if (len == '0)         stateNext = DONE;
               else if (op == OP_COPY) stateNext = READ;
               else                    stateNext = WRITE;
            end
         end
         READ:  stateNext = WRITE;
         WRITE: begin
            if (count == LEN_W'(1))  stateNext = DONE;
            else if (opQ == OP_COPY) stateNext = READ;
            else                     stateNext = WRITE;
         end
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Outputs depend on registered state only. Address/data fall back to the
   // last driven values so the bus stays stable in IDLE, READ data and DONE.
   always_comb begin
      busy        = (state != IDLE);
      done        = (state == DONE);
      mem_wEn     = (state == WRITE);
      mem_address = lastAddr;
      mem_data    = lastData;
      case (state)
         READ:  mem_address = srcPtr;
         WRITE: begin
            mem_address = dstPtr;
            mem_data    = (opQ == OP_COPY) ? holdQ : fillQ;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         opQ      <= OP_COPY;
         fillQ    <= '0;
         holdQ    <= '0;
         count    <= '0;
         lastAddr <= '0;
         lastData <= '0;
      end else begin
         state    <= stateNext;
         lastAddr <= mem_address;
         lastData <= mem_data;
         if (accept) begin
            opQ   <= op;
            fillQ <= fill_value;
            count <= len;
         end
         if (state == READ)  holdQ <= mem_outData;
         if (state == WRITE) count <= count - LEN_W'(1);
      end
   end

endmodule

// File: tb/tb_mem_copy_engine.sv
module tb_mem_copy_engine;
   import mem_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        opIn = 1'b0;
   logic [15:0] srcAddr = '0, dstAddr = '0, lenIn = '0, fillValue = '0;
   logic        busy, done, memWEn;
   logic [15:0] memAddress, memData, memOutData;

   mem_copy_engine dut (
      .clk(clk), .reset(reset), .start(start), .op(opIn),
      .src_addr(srcAddr), .dst_addr(dstAddr), .len(lenIn), .fill_value(fillValue),
      .busy(busy), .done(done), .mem_address(memAddress), .mem_data(memData),
      .mem_wEn(memWEn), .mem_outData(memOutData)
   );

   always #5 clk = ~clk;

   // memory_block model: combinational read, clocked write, plus a bench-only
   // preload port and a one-shot bulk initialiser.
   logic [15:0] tbMem  [0:65535];
   logic [15:0] refMem [0:65535];
   logic        initReq = 1'b0, preWr = 1'b0;
   logic [15:0] preAddr = '0, preData = '0, seed = '0;

   function automatic logic [15:0] memInit(input logic [15:0] s, input int a);
      logic [31:0] t;
      t = a * 32'h9E37;
      return t[15:0] ^ s;
   endfunction

   assign memOutData = tbMem[memAddress];

   always @(posedge clk) begin
      if (initReq) begin
         for (int i = 0; i < 65536; i++) tbMem[i] <= memInit(seed, i);
      end else if (memWEn) tbMem[memAddress] <= memData;
      else if (preWr)      tbMem[preAddr]    <= preData;
   end

   typedef struct {
      logic        op;
      logic [15:0] src, dst, len, fill;
      int          expDone;
   } xferT;

   xferT sbQ[$];
   int   doneLog[$];
   int   checks = 0, failures = 0;
   int   cycleCnt = 0, wenCnt = 0, busyCnt = 0;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cycleCnt);
      end
   endtask

   // Cycles from the accepting edge to the done cycle.
   function automatic int refLatency(input logic o, input logic [15:0] l);
      if (l == 0) return 1;
      return (o == OP_FILL) ? int'(l) + 1 : 2 * int'(l) + 1;
   endfunction

   // Forward, word-by-word effect of one transfer on memory (overlap included).
   task automatic applyXfer(input logic o, input logic [15:0] s, input logic [15:0] d,
                            input int n, input logic [15:0] f);
      for (int i = 0; i < n; i++) begin
         logic [15:0] da, sa;
         da = d + 16'(i);
         sa = s + 16'(i);
         refMem[da] = (o == OP_FILL) ? f : refMem[sa];
      end
   endtask

   task automatic checkMem(input string name);
      int bad, firstBad;
      bad = 0;
      firstBad = -1;
      for (int i = 0; i < 65536; i++) begin
         if (tbMem[i] !== refMem[i]) begin
            if (firstBad < 0) firstBad = i;
            bad++;
         end
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL %s: %0d words differ, first at 0x%0h got 0x%0h expected 0x%0h",
                  name, bad, firstBad, tbMem[firstBad], refMem[firstBad]);
      end
   endtask

   // Monitor: observes acceptance and completion, scores against the queue.
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            sbQ.delete();
            wenCnt  = 0;
            busyCnt = 0;
         end else begin
            if (memWEn) wenCnt++;
            if (busy) busyCnt++;
            if (start && !busy) begin
               xferT x;
               x.op = opIn; x.src = srcAddr; x.dst = dstAddr; x.len = lenIn; x.fill = fillValue;
               x.expDone = cycleCnt + refLatency(opIn, lenIn);
               sbQ.push_back(x);
            end
            if (done) begin
               doneLog.push_back(cycleCnt);
               if (sbQ.size() == 0) begin
                  chk("spuriousDone", 1, 0);
               end else begin
                  xferT x;
                  x = sbQ.pop_front();
                  chk("doneCycle", cycleCnt, x.expDone);
                  chk("wEnCycles", wenCnt, int'(x.len));
                  chk("busyCycles", busyCnt, refLatency(x.op, x.len));
                  applyXfer(x.op, x.src, x.dst, int'(x.len), x.fill);
                  checkMem("memImage");
               end
               wenCnt  = 0;
               busyCnt = 0;
            end
         end
      end
   end

   task automatic waitIdle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (!busy) begin ok = 1'b1; break; end
      end
      if (!ok) chk("idleTimeout", 1, 0);
   endtask

   task automatic issue(input logic o, input logic [15:0] s, input logic [15:0] d,
                        input logic [15:0] l, input logic [15:0] f);
      waitIdle();
      opIn = o; srcAddr = s; dstAddr = d; lenIn = l; fillValue = f;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic drain();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (sbQ.size() == 0 && !busy) begin ok = 1'b1; break; end
         @(posedge clk); #1;
      end
      if (!ok) chk("drainTimeout", 1, 0);
   endtask

   task automatic preload(input logic [15:0] a, input logic [15:0] v);
      preWr = 1'b1; preAddr = a; preData = v;
      refMem[a] = v;
      @(posedge clk); #1;
      preWr = 1'b0;
   endtask

   initial begin
      int n0;
      seed = 16'($urandom);
      initReq = 1'b1;
      @(posedge clk); #1;
      initReq = 1'b0;
      for (int i = 0; i < 65536; i++) refMem[i] = memInit(seed, i);

      // reset state
      chk("rstBusy", busy, 0);
      chk("rstDone", done, 0);
      chk("rstWEn", memWEn, 0);
      chk("rstAddr", memAddress, 0);
      chk("rstData", memData, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      chk("idleBusy", busy, 0);
      chk("idleWEn", memWEn, 0);

      // 1: FILL
      issue(OP_FILL, 16'h0000, 16'h0010, 16'd4, 16'h0F0F);
      drain();
      for (int i = 0; i < 4; i++) chk("t1Mem", tbMem[16'h0010 + i], 16'h0F0F);

      // 2: COPY
      preload(16'h0000, 16'd1);
      preload(16'h0001, 16'd2);
      preload(16'h0002, 16'd3);
      issue(OP_COPY, 16'h0000, 16'h0100, 16'd3, 16'h0000);
      drain();
      for (int i = 0; i < 3; i++) chk("t2Mem", tbMem[16'h0100 + i], i + 1);

      // 3: zero length, both ops
      issue(OP_COPY, 16'h0020, 16'h0030, 16'd0, 16'h1234);
      issue(OP_FILL, 16'h0020, 16'h0030, 16'd0, 16'h1234);
      drain();

      // 4: wrap
      issue(OP_FILL, 16'h0000, 16'hFFFE, 16'd3, 16'hAAAA);
      drain();
      chk("t4MemFFFE", tbMem[16'hFFFE], 16'hAAAA);
      chk("t4MemFFFF", tbMem[16'hFFFF], 16'hAAAA);
      chk("t4Mem0000", tbMem[16'h0000], 16'hAAAA);

      // 5a: start pulses while busy are dropped
      n0 = doneLog.size();
      issue(OP_COPY, 16'h0200, 16'h0300, 16'd5, 16'h0000);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         opIn = OP_FILL; dstAddr = 16'h0400; lenIn = 16'd1; fillValue = 16'hDEAD;
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
      drain();
      chk("ignoredStartDones", doneLog.size() - n0, 1);

      // 5b: start held -> back-to-back
      waitIdle();
      n0 = doneLog.size();
      opIn = OP_FILL; srcAddr = 16'h0; dstAddr = 16'h0500; lenIn = 16'd3; fillValue = 16'h5A5A;
      start = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (done) break;
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      start = 1'b0;
      drain();
      chk("b2bDones", doneLog.size() - n0, 2);
      if (doneLog.size() >= 2)
         chk("b2bGap", doneLog[doneLog.size()-1] - doneLog[doneLog.size()-2], 5);

      // 6: reset mid-COPY after two words
      n0 = doneLog.size();
      issue(OP_COPY, 16'h0600, 16'h0700, 16'd5, 16'h0000);
      repeat (5) @(posedge clk);
      #1;
      chk("preRstWEn", memWEn, 1);
      #2 reset = 1'b1;
      #1;
      chk("midRstBusy", busy, 0);
      chk("midRstWEn", memWEn, 0);
      chk("midRstDone", done, 0);
      applyXfer(OP_COPY, 16'h0600, 16'h0700, 2, 16'h0000);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      chk("rstNoDone", doneLog.size() - n0, 0);
      checkMem("rstMem");

      // random traffic
      for (int t = 0; t < 24; t++) begin
         logic        o;
         logic [15:0] s, d, l, f;
         o = 1'($urandom_range(0, 1));
         s = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7)) : 16'($urandom);
         d = ($urandom_range(0, 3) == 0) ? s + 16'($urandom_range(0, 4)) : 16'($urandom);
         l = 16'($urandom_range(0, 9));
         f = 16'($urandom);
         issue(o, s, d, l, f);
         if ($urandom_range(0, 3) == 0) begin
            opIn = 1'($urandom_range(0, 1)); dstAddr = 16'($urandom);
            lenIn = 16'($urandom_range(0, 3)); fillValue = 16'($urandom);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
         end
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
